// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the gray-code receive path.
//   - tracker state encodings (IDLE / TRACK / FAULT)
//   - default code width and wrap-counter width
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 3;
  localparam int GRAY_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } gray_state_e;

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational gray-to-binary decoder.
//   gray   : WIDTH-bit gray-coded input
//   binary : WIDTH-bit decoded binary value
// Each binary bit is the XOR of all gray bits at and above its position,
// written as a reduction so no bit depends on another output bit.
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign binary[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_decoder.sv
// gray_decoder: samples a gray-coded count stream, decodes it to binary and
// checks that each step is a legal single-bit gray increment.
//
// Ports:
//   Clk       : clock, rising edge
//   Reset     : asynchronous active-low reset
//   En        : sample-valid; Gray consumed on rising Clk when high
//   Gray      : gray-coded count (WIDTH bits)
//   ClrErr    : clear sticky error, drop Valid and return to IDLE
//   Binary    : registered decode of the last accepted sample
//   Valid     : at least one sample accepted since reset/clear
//   Wrap      : one-cycle pulse after a legal max->0 step
//   Restart   : one-cycle pulse after a jump to 0 from a non-max value
//   WrapCount : number of wraps, modulo 2^CNT_W
//   Error     : sticky illegal-transition flag
//
// Build option: define GRAY_DEC_DOWN_EN to accept a decrement by one as a
// legal step while tracking; otherwise a decrement is an illegal transition.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF,
  parameter int CNT_W = GRAY_CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] Gray,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] Binary,
  output logic             Valid,
  output logic             Wrap,
  output logic             Restart,
  output logic [CNT_W-1:0] WrapCount,
  output logic             Error
);

  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  gray_state_e      state_r, state_nxt_s;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] binary_r, binary_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             wrap_r, wrap_nxt_s;
  logic             restart_r, restart_nxt_s;
  logic [CNT_W-1:0] wrap_count_r, wrap_count_nxt_s;
  logic             error_r, error_nxt_s;

  logic step_hold_s, step_inc_s, step_restart_s, step_dec_s;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray   (Gray),
    .binary (dec_s)
  );

  // Classify the incoming sample relative to the current reference value.
  assign step_hold_s    = (dec_s == binary_r);
  assign step_inc_s     = (dec_s == binary_r + ONE_C);
  assign step_restart_s = (dec_s == ZERO_C) && (binary_r != MAX_C);
`ifdef GRAY_DEC_DOWN_EN
  assign step_dec_s     = (dec_s == binary_r - ONE_C);
`else
  assign step_dec_s     = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; ClrErr wins over a same-cycle sample.
  always_comb begin
    state_nxt_s = state_r;
    if (ClrErr) begin
      state_nxt_s = ST_IDLE;
    end else if (En) begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_TRACK;
        ST_TRACK: begin
          if (step_hold_s || step_inc_s || step_restart_s || step_dec_s) begin
            state_nxt_s = ST_TRACK;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end
        ST_FAULT: state_nxt_s = ST_FAULT;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output next-value logic; pulses default low every cycle.
  always_comb begin
    binary_nxt_s     = binary_r;
    valid_nxt_s      = valid_r;
    wrap_nxt_s       = 1'b0;
    restart_nxt_s    = 1'b0;
    wrap_count_nxt_s = wrap_count_r;
    error_nxt_s      = error_r;
    if (ClrErr) begin
      valid_nxt_s = 1'b0;
      error_nxt_s = 1'b0;
    end else if (En) begin
      case (state_r)
        ST_IDLE: begin
          binary_nxt_s = dec_s;
          valid_nxt_s  = 1'b1;
        end
        ST_TRACK: begin
          if (step_hold_s) begin
            binary_nxt_s = binary_r;
          end else if (step_inc_s) begin
            binary_nxt_s = dec_s;
            if (binary_r == MAX_C) begin
              wrap_nxt_s       = 1'b1;
              wrap_count_nxt_s = wrap_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              wrap_nxt_s = 1'b0;
            end
          end else if (step_restart_s) begin
            binary_nxt_s  = ZERO_C;
            restart_nxt_s = 1'b1;
          end else if (step_dec_s) begin
            binary_nxt_s = dec_s;
          end else begin
            binary_nxt_s = dec_s;
            error_nxt_s  = 1'b1;
          end
        end
        ST_FAULT: begin
          // Follow the stream without checking until cleared.
          binary_nxt_s = dec_s;
        end
        default: begin
          binary_nxt_s = binary_r;
        end
      endcase
    end else begin
      binary_nxt_s = binary_r;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      binary_r     <= ZERO_C;
      valid_r      <= 1'b0;
      wrap_r       <= 1'b0;
      restart_r    <= 1'b0;
      wrap_count_r <= {CNT_W{1'b0}};
      error_r      <= 1'b0;
    end else begin
      binary_r     <= binary_nxt_s;
      valid_r      <= valid_nxt_s;
      wrap_r       <= wrap_nxt_s;
      restart_r    <= restart_nxt_s;
      wrap_count_r <= wrap_count_nxt_s;
      error_r      <= error_nxt_s;
    end
  end

  assign Binary    = binary_r;
  assign Valid     = valid_r;
  assign Wrap      = wrap_r;
  assign Restart   = restart_r;
  assign WrapCount = wrap_count_r;
  assign Error     = error_r;

endmodule

// File: tb/tb_gray_decoder.sv
// Table-driven bench for gray_decoder: directed vectors with hand-computed
// expectations, plus hand-written async-reset and decrement sequences.
module tb_gray_decoder;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] Gray;
  logic       ClrErr;
  logic [2:0] Binary;
  logic       Valid;
  logic       Wrap;
  logic       Restart;
  logic [7:0] WrapCount;
  logic       Error;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       en;
    logic       clr;
    logic [2:0] gray;
    logic [2:0] binary;
    logic       valid;
    logic       wrap;
    logic       restart;
    logic [7:0] wc;
    logic       error;
  } vec_t;

  vec_t vecs[$];

  gray_decoder dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (En),
    .Gray      (Gray),
    .ClrErr    (ClrErr),
    .Binary    (Binary),
    .Valid     (Valid),
    .Wrap      (Wrap),
    .Restart   (Restart),
    .WrapCount (WrapCount),
    .Error     (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] b, input logic v,
                         input logic w, input logic r, input logic [7:0] wc,
                         input logic e);
    chk({tag, ".Binary"},    32'(Binary),    32'(b));
    chk({tag, ".Valid"},     32'(Valid),     32'(v));
    chk({tag, ".Wrap"},      32'(Wrap),      32'(w));
    chk({tag, ".Restart"},   32'(Restart),   32'(r));
    chk({tag, ".WrapCount"}, 32'(WrapCount), 32'(wc));
    chk({tag, ".Error"},     32'(Error),     32'(e));
  endtask

  // Drive on the falling edge, let the rising edge sample, settle 1 time unit.
  task automatic apply(input logic en, input logic clr, input logic [2:0] g);
    @(negedge Clk);
    En     = en;
    ClrErr = clr;
    Gray   = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic en, input logic clr, input logic [2:0] g,
                     input logic [2:0] b, input logic v, input logic w,
                     input logic r, input logic [7:0] wc, input logic e);
    vec_t t;
    t.en = en; t.clr = clr; t.gray = g; t.binary = b; t.valid = v;
    t.wrap = w; t.restart = r; t.wc = wc; t.error = e;
    vecs.push_back(t);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    Reset  = 1'b0;
    En     = 1'b0;
    ClrErr = 1'b0;
    Gray   = 3'b000;

    //   en    clr   gray    bin   val   wrap  rst   wc     err
    // full up-count with wrap
    add(1'b1, 1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b110, 3'd4, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 3'd5, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b101, 3'd6, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b100, 3'd7, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    add(1'b1, 1'b0, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
    // idle cycle clears the pulse, ignores Gray
    add(1'b0, 1'b0, 3'b101, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    // hold at 2 for three samples
    add(1'b1, 1'b0, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    // up to 5 then restart to 0
    add(1'b1, 1'b0, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b110, 3'd4, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b111, 3'd5, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
    // 2 -> 6 is illegal; FAULT then follows without pulses
    add(1'b1, 1'b0, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b101, 3'd6, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
    add(1'b1, 1'b0, 3'b100, 3'd7, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
    add(1'b1, 1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
    // ClrErr beats a same-cycle sample; next sample is a fresh reference
    add(1'b1, 1'b1, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
    add(1'b1, 1'b0, 3'b110, 3'd4, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);

    // Reset state
    #12;
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].en, vecs[i].clr, vecs[i].gray);
      chk_all($sformatf("vec%0d", i), vecs[i].binary, vecs[i].valid,
              vecs[i].wrap, vecs[i].restart, vecs[i].wc, vecs[i].error);
    end

    // Asynchronous reset between edges while Binary=4
    @(negedge Clk);
    En = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    apply(1'b1, 1'b0, 3'b110);
    chk_all("post_rst", 3'd4, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // ClrErr without a sample: back to IDLE, Binary retained
    apply(1'b0, 1'b1, 3'b000);
    chk_all("clr_only", 3'd4, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Decrement 3 -> 2
    apply(1'b1, 1'b0, 3'b010);
    chk_all("dec_ref", 3'd3, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    apply(1'b1, 1'b0, 3'b011);
`ifdef GRAY_DEC_DOWN_EN
    chk_all("dec_step", 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
`else
    chk_all("dec_step", 3'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
`endif

    @(negedge Clk);
    En = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
